// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction-fetch controller.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ_PC   = 3'd1,
    BUS_WAIT = 3'd2,
    MEM_REQ  = 3'd3,
    WAIT_ACK = 3'd4,
    INCR     = 3'd5,
    DELIVER  = 3'd6,
    ERROR    = 3'd7
  } fetch_state_e;

  // Width of a counter that must be able to hold the value t.
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller signal bundle: PC bus, memory read port, decode handshake
// and status. master = fetch_ctrl side, slave = PC / memory / decoder side.
interface fetch_ctrl_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              start;
  logic              halt;
  logic [ADDR_W-1:0] bus_in;
  logic              pc_en;
  logic              pc_incr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              busy;
  logic              err_timeout;

  modport master (
    input  start, halt, bus_in, mem_rdata, mem_ack, instr_ready,
    output pc_en, pc_incr, mem_req, mem_addr, instr, instr_pc, instr_valid,
           busy, err_timeout
  );

  modport slave (
    output start, halt, bus_in, mem_rdata, mem_ack, instr_ready,
    input  pc_en, pc_incr, mem_req, mem_addr, instr, instr_pc, instr_valid,
           busy, err_timeout
  );

endinterface

// File: rtl/fetch_timeout_cnt.sv
// Memory-wait watchdog: clear/enable counter whose terminal flag marks the
// enabled cycle that brings the count up to TIMEOUT.
module fetch_timeout_cnt
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != CNT_W'(TIMEOUT)))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // The current enabled cycle is the TIMEOUT-th one.
  assign term_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: reads the PC off the shared bus, issues a
// memory read, pulses the PC increment and hands the word to decode.
// Every output is a register loaded from the next state, so the outputs
// line up exactly with the state they describe.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic              pc_en_q, pc_en_d;
  logic              pc_incr_q, pc_incr_d;
  logic              mem_req_q, mem_req_d;
  logic              instr_valid_q, instr_valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;

  logic go;
  logic to_clr, to_en, to_term;

  // halt always overrides start; only consulted at the IDLE and DELIVER exits.
  assign go     = bus.start && !bus.halt;
  assign to_clr = (state_q == MEM_REQ);
  assign to_en  = (state_q == WAIT_ACK);

  fetch_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_to_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (to_clr),
    .en_i   (to_en),
    .term_o (to_term)
  );

  // Next state, next outputs and the data captures.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE:     if (go) state_d = REQ_PC;
      REQ_PC:   state_d = BUS_WAIT;
      BUS_WAIT: begin
        // PC drives the bus this cycle in answer to last cycle's pc_en.
        mem_addr_d = bus.bus_in;
        state_d    = MEM_REQ;
      end
      MEM_REQ:  state_d = WAIT_ACK;
      WAIT_ACK: begin
        // An ack on the terminal cycle still completes the fetch.
        if (bus.mem_ack) begin
          instr_d    = bus.mem_rdata;
          instr_pc_d = mem_addr_q;
          state_d    = INCR;
        end else if (to_term) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end
      end
      INCR:     state_d = DELIVER;
      DELIVER:  if (bus.instr_ready) state_d = go ? REQ_PC : IDLE;
      ERROR:    state_d = ERROR;
      default:  state_d = IDLE;
    endcase

    pc_en_d       = (state_d == REQ_PC);
    pc_incr_d     = (state_d == INCR);
    mem_req_d     = (state_d == MEM_REQ) || (state_d == WAIT_ACK);
    instr_valid_d = (state_d == DELIVER);
    busy_d        = (state_d != IDLE) && (state_d != ERROR);
  end

  // State and output registers; reset aborts any fetch in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_en_q       <= 1'b0;
      pc_incr_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      mem_addr_q    <= '0;
      instr_pc_q    <= '0;
      instr_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_en_q       <= pc_en_d;
      pc_incr_q     <= pc_incr_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      mem_addr_q    <= mem_addr_d;
      instr_pc_q    <= instr_pc_d;
      instr_q       <= instr_d;
    end
  end

  assign bus.pc_en       = pc_en_q;
  assign bus.pc_incr     = pc_incr_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;

endmodule
